// File: rtl/pll_lock_ctrl.sv
// PLL bring-up and lock supervision controller.
// Sequences PLL reset, lock wait with retry, settle, then releases downstream.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 64,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       ref_clk,
  input  logic       RST_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst_n,
  output logic       sys_rst_n,
  output logic       clk_en,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic       lock_lost,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  localparam logic [7:0] RST_LAST =
    8'(RST_CYCLES - 1);
  localparam logic [7:0] TMO_LAST =
    8'(LOCK_TIMEOUT - 1);
  localparam logic [7:0] SET_LAST =
    8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] RETRY_MAX =
    2'(MAX_RETRY);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] retry_q, retry_d;
  logic       lost_q, lost_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       pll_rst_n_q, pll_rst_n_d;
  logic       sys_rst_n_q, sys_rst_n_d;
  logic       clk_en_q, clk_en_d;
  logic       fail_q, fail_d;
  logic       locked_s;

  assign locked_s = sync2_q;

  // Next-state, counter, retry and sticky-flag decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    sync1_d = pll_locked;
    sync2_d = sync1_q;
    if (restart) begin
      state_d = S_RST;
      retry_d = 2'd0;
      lost_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_RST: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == RST_LAST)
            state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (locked_s) begin
            state_d = S_SETTLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = S_RST;
            end
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (!locked_s) begin
            state_d = S_WAIT;
          end else if (cnt_q == SET_LAST) begin
            state_d = S_RUN;
            retry_d = 2'd0;
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            lost_d  = 1'b1;
            state_d = S_RST;
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_RST;
      endcase
    end
    if (restart || state_d != state_q)
      cnt_d = 8'd0;
  end

  // Registered outputs decoded from the next state
  always_comb begin
    pll_rst_n_d = !(state_d == S_RST ||
                    state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    clk_en_d    = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  // State, counters, synchronizer and output flops
  always_ff @(posedge ref_clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_RST;
      cnt_q       <= 8'd0;
      retry_q     <= 2'd0;
      lost_q      <= 1'b0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      pll_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      clk_en_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pll_rst_n_q <= pll_rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      clk_en_q    <= clk_en_d;
      fail_q      <= fail_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;
  assign pll_rst_n = pll_rst_n_q;
  assign sys_rst_n = sys_rst_n_q;
  assign clk_en    = clk_en_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl.
// Edge numbers in step comments count ref_clk edges after RST_n release.
module tb_pll_lock_ctrl;

  logic       ref_clk;
  logic       RST_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst_n;
  logic       sys_rst_n;
  logic       clk_en;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic       lock_lost;
  logic       fail;

  int n_pass;
  int n_total;

  pll_lock_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (64),
    .SETTLE_CYCLES(8),
    .MAX_RETRY    (3)
  ) dut (
    .ref_clk   (ref_clk),
    .RST_n     (RST_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst_n (pll_rst_n),
    .sys_rst_n (sys_rst_n),
    .clk_en    (clk_en),
    .state     (state),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost),
    .fail      (fail)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  task automatic step(input int n);
    repeat (n) @(posedge ref_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic release_rst();
    @(negedge ref_clk);
    RST_n = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    RST_n = 1'b1;
    pll_locked = 1'b0;
    restart = 1'b0;

    #2 RST_n = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_pll_rst_n", int'(pll_rst_n), 0);
    chk("rst_sys_rst_n", int'(sys_rst_n), 0);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_retry", int'(retry_cnt), 0);
    chk("rst_lock_lost", int'(lock_lost), 0);
    chk("rst_fail", int'(fail), 0);

    // nominal bring-up
    release_rst();
    step(3);
    chk("e3_state", int'(state), 0);
    chk("e3_pll_rst_n", int'(pll_rst_n), 0);
    step(1);
    chk("e4_pll_rst_n", int'(pll_rst_n), 1);
    chk("e4_state", int'(state), 1);
    step(3);
    pll_locked = 1'b1;
    step(2);
    chk("e9_state", int'(state), 1);
    step(1);
    chk("e10_settle", int'(state), 2);
    step(7);
    chk("e17_state", int'(state), 2);
    chk("e17_sys_rst_n", int'(sys_rst_n), 0);
    step(1);
    chk("e18_run", int'(state), 3);
    chk("e18_sys_rst_n", int'(sys_rst_n), 1);
    chk("e18_clk_en", int'(clk_en), 1);
    chk("e18_retry", int'(retry_cnt), 0);

    // lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    chk("e20_still_run", int'(state), 3);
    step(1);
    chk("e21_state", int'(state), 0);
    chk("e21_sys_rst_n", int'(sys_rst_n), 0);
    chk("e21_clk_en", int'(clk_en), 0);
    chk("e21_pll_rst_n", int'(pll_rst_n), 0);
    chk("e21_lock_lost", int'(lock_lost), 1);
    step(4);
    chk("e25_wait", int'(state), 1);
    step(3);
    pll_locked = 1'b1;
    step(11);
    chk("e39_run", int'(state), 3);
    chk("e39_lock_lost", int'(lock_lost), 1);

    // restart held for three cycles
    restart = 1'b1;
    pll_locked = 1'b0;
    step(1);
    chk("e40_state", int'(state), 0);
    chk("e40_lock_lost", int'(lock_lost), 0);
    chk("e40_pll_rst_n", int'(pll_rst_n), 0);
    chk("e40_sys_rst_n", int'(sys_rst_n), 0);
    step(2);
    chk("e42_held", int'(state), 0);
    restart = 1'b0;
    step(3);
    chk("e45_state", int'(state), 0);
    step(1);
    chk("e46_wait", int'(state), 1);

    // one-cycle lock glitch in SETTLE
    step(3);
    pll_locked = 1'b1;
    step(3);
    chk("e52_settle", int'(state), 2);
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    chk("e57_settle", int'(state), 2);
    step(1);
    chk("e58_wait", int'(state), 1);
    step(1);
    chk("e59_settle", int'(state), 2);
    chk("e59_retry", int'(retry_cnt), 0);
    step(7);
    chk("e66_settle", int'(state), 2);
    step(1);
    chk("e67_run", int'(state), 3);
    chk("e67_clk_en", int'(clk_en), 1);

    // restart mid-SETTLE
    pll_locked = 1'b0;
    step(3);
    chk("e70_rst", int'(state), 0);
    chk("e70_lock_lost", int'(lock_lost), 1);
    step(7);
    pll_locked = 1'b1;
    step(3);
    chk("e80_settle", int'(state), 2);
    step(2);
    restart = 1'b1;
    pll_locked = 1'b0;
    step(1);
    chk("e83_state", int'(state), 0);
    chk("e83_lock_lost", int'(lock_lost), 0);
    chk("e83_retry", int'(retry_cnt), 0);
    restart = 1'b0;
    step(4);
    chk("e87_wait", int'(state), 1);
    step(3);
    pll_locked = 1'b1;
    step(11);
    chk("e101_run", int'(state), 3);
    chk("e101_sys_rst_n", int'(sys_rst_n), 1);

    // async reset from RUN, then no lock ever
    #2 RST_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    chk("ar_state", int'(state), 0);
    chk("ar_sys_rst_n", int'(sys_rst_n), 0);
    chk("ar_clk_en", int'(clk_en), 0);
    chk("ar_pll_rst_n", int'(pll_rst_n), 0);
    release_rst();
    step(67);
    chk("f67_retry", int'(retry_cnt), 0);
    chk("f67_state", int'(state), 1);
    step(1);
    chk("f68_retry", int'(retry_cnt), 1);
    chk("f68_state", int'(state), 0);
    step(68);
    chk("f136_retry", int'(retry_cnt), 2);
    step(68);
    chk("f204_retry", int'(retry_cnt), 3);
    step(67);
    chk("f271_state", int'(state), 1);
    chk("f271_fail", int'(fail), 0);
    step(1);
    chk("f272_state", int'(state), 4);
    chk("f272_fail", int'(fail), 1);
    chk("f272_pll_rst_n", int'(pll_rst_n), 0);
    step(10);
    chk("f282_state", int'(state), 4);
    chk("f282_retry", int'(retry_cnt), 3);
    chk("f282_pll_rst_n", int'(pll_rst_n), 0);

    // restart from FAIL
    restart = 1'b1;
    step(1);
    chk("fr_state", int'(state), 0);
    chk("fr_retry", int'(retry_cnt), 0);
    chk("fr_fail", int'(fail), 0);
    restart = 1'b0;
    step(4);
    chk("fr_wait", int'(state), 1);
    step(3);
    pll_locked = 1'b1;
    step(11);
    chk("fr_run", int'(state), 3);
    chk("fr_run_retry", int'(retry_cnt), 0);

    // async reset mid-WAIT_LOCK with retry_cnt=2
    #2 RST_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    release_rst();
    step(140);
    chk("r140_state", int'(state), 1);
    chk("r140_retry", int'(retry_cnt), 2);
    step(5);
    #2 RST_n = 1'b0;
    #1;
    chk("r_state", int'(state), 0);
    chk("r_retry", int'(retry_cnt), 0);
    chk("r_pll_rst_n", int'(pll_rst_n), 0);
    chk("r_fail", int'(fail), 0);
    chk("r_lock_lost", int'(lock_lost), 0);
    release_rst();
    step(4);
    chk("r4_state", int'(state), 1);
    chk("r4_retry", int'(retry_cnt), 0);
    step(64);
    chk("r68_retry", int'(retry_cnt), 1);
    chk("r68_state", int'(state), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
